// File: rtl/gg_chdc_insert.sv
// gg_chdc_insert: chroma DC inserter between the DRAM MB read port and the transform pipe.
// Passes every 4x4 pel block of a macroblock through (16 luma, NCB Cb, NCB Cr), sums the 16 pels
// of each chroma block into a per-block DC slot, and appends a Cb DC word and a Cr DC word
// after the final Cr block. The Cr DC word carries m_last.
// Optional build macro GG_CHDC_STATS_EN adds saturating stat_mb_count / stat_resync_count outputs;
// without it those ports and counters do not exist and the data path is unchanged.
module gg_chdc_insert #(
  parameter  int PEL_BITS   = 8,
  parameter  int CHROMA_FMT = 0,
  localparam int DATA_W     = 16 * PEL_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_dc,
  output logic              resync_err
`ifdef GG_CHDC_STATS_EN
  ,
  output logic [31:0]       stat_mb_count,
  output logic [15:0]       stat_resync_count
`endif
);

  // Derived geometry: one DC sum of 16 pels never exceeds PEL_BITS+4 bits.
  localparam int DC_W     = PEL_BITS + 4;
  localparam int NCB      = (CHROMA_FMT == 1) ? 8 : 4;
  localparam int MB_BEATS = 16 + 2 * NCB;
  localparam int CNT_W    = $clog2(MB_BEATS);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MB_BEATS - 1);
  localparam logic [CNT_W-1:0] CB_BASE   = CNT_W'(16);
  localparam logic [CNT_W-1:0] CR_BASE   = CNT_W'(16 + NCB);

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_CBDC = 2'd1,
    ST_CRDC = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [CNT_W-1:0]  r_count;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_last;
  logic              r_m_dc;
  logic              r_resync_err;

  logic              w_out_free;
  logic              w_accept;
  logic              w_final;
  logic              w_early_last;
  logic              w_dc_clear;
  logic              w_is_cb;
  logic              w_is_cr;
  logic [CNT_W-1:0]  w_cb_off;
  logic [CNT_W-1:0]  w_cr_off;
  logic [DC_W-1:0]   w_blk_sum;
  logic [DATA_W-1:0] w_cb_word;
  logic [DATA_W-1:0] w_cr_word;

  logic              w_ld_valid;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_ld_last;
  logic              w_ld_dc;

  // ------------------------------------------------------------------
  // Handshake and beat classification
  // ------------------------------------------------------------------
  // The single output register can take a new word when empty or being drained this cycle.
  assign w_out_free = !r_m_valid || m_ready;
  // Input is only taken while passing blocks; the two DC beats are the two bubbles per MB.
  assign s_ready    = (r_state == ST_PASS) && w_out_free;
  assign w_accept   = s_valid && s_ready;

  // A beat ends the MB either by position or by an explicit s_last (which may arrive early).
  assign w_final      = w_accept && ((r_count == LAST_BEAT) || s_last);
  assign w_early_last = w_accept && s_last && (r_count != LAST_BEAT);

  assign w_is_cb  = (r_count >= CB_BASE) && (r_count < CR_BASE);
  assign w_is_cr  = (r_count >= CR_BASE);
  assign w_cb_off = r_count - CB_BASE;
  assign w_cr_off = r_count - CR_BASE;

  // DC slots are cleared the cycle the Cr DC word is loaded, so a short (resynced) MB
  // reports zero for every block it never delivered.
  assign w_dc_clear = (r_state == ST_CRDC) && w_out_free;

  // Unsigned sum of the 16 pels of the incoming block.
  always_comb begin
    w_blk_sum = '0;
    for (int i = 0; i < 16; i++) begin
      w_blk_sum = w_blk_sum + DC_W'(s_data[i*PEL_BITS +: PEL_BITS]);
    end
  end

  // ------------------------------------------------------------------
  // Per-block DC slots and DC word packing
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < NCB; gi++) begin : g_slot
    logic [DC_W-1:0] r_cb_dc;
    logic [DC_W-1:0] r_cr_dc;

    // Capture the DC of chroma block gi as it passes; cleared after the Cr DC word goes out.
    always_ff @(posedge clk) begin
      if (reset || w_dc_clear) begin
        r_cb_dc <= '0;
        r_cr_dc <= '0;
      end else if (w_accept) begin
        if (w_is_cb && (w_cb_off == CNT_W'(gi))) begin
          r_cb_dc <= w_blk_sum;
        end
        if (w_is_cr && (w_cr_off == CNT_W'(gi))) begin
          r_cr_dc <= w_blk_sum;
        end
      end
    end

    assign w_cb_word[gi*DC_W +: DC_W] = r_cb_dc;
    assign w_cr_word[gi*DC_W +: DC_W] = r_cr_dc;
  end

  // Bits above the last DC field are always zero.
  if (NCB * DC_W < DATA_W) begin : g_pad
    assign w_cb_word[DATA_W-1:NCB*DC_W] = '0;
    assign w_cr_word[DATA_W-1:NCB*DC_W] = '0;
  end

  // ------------------------------------------------------------------
  // Insertion FSM
  // ------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_PASS;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: leave PASS on the MB's final beat, then step through the two DC loads.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_PASS: if (w_final)    w_state_next = ST_CBDC;
      ST_CBDC: if (w_out_free) w_state_next = ST_CRDC;
      ST_CRDC: if (w_out_free) w_state_next = ST_PASS;
      default:                 w_state_next = ST_PASS;
    endcase
  end

  // Output selection: what the output register loads when it is free.
  always_comb begin
    w_ld_valid = 1'b0;
    w_ld_data  = s_data;
    w_ld_last  = 1'b0;
    w_ld_dc    = 1'b0;
    case (r_state)
      ST_PASS: begin
        w_ld_valid = w_accept;
      end
      ST_CBDC: begin
        w_ld_valid = 1'b1;
        w_ld_data  = w_cb_word;
        w_ld_dc    = 1'b1;
      end
      ST_CRDC: begin
        w_ld_valid = 1'b1;
        w_ld_data  = w_cr_word;
        w_ld_dc    = 1'b1;
        w_ld_last  = 1'b1;
      end
      default: begin
        w_ld_valid = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  // Output register: holds steady while stalled, reloads whenever it is free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_m_dc    <= 1'b0;
    end else if (w_out_free) begin
      r_m_valid <= w_ld_valid;
      r_m_data  <= w_ld_data;
      r_m_last  <= w_ld_last;
      r_m_dc    <= w_ld_dc;
    end
  end

  // Beat position within the MB; restarts at 0 after every final beat, early or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= w_final ? '0 : (r_count + CNT_W'(1));
    end
  end

  // One-cycle pulse flagging an s_last that arrived before the MB's last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resync_err <= 1'b0;
    end else begin
      r_resync_err <= w_early_last;
    end
  end

  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign m_dc       = r_m_dc;
  assign resync_err = r_resync_err;

`ifdef GG_CHDC_STATS_EN
  logic [31:0] r_stat_mb;
  logic [15:0] r_stat_resync;

  // Saturating counters: completed MBs (Cr DC word handed off) and resync events.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_mb     <= '0;
      r_stat_resync <= '0;
    end else begin
      if (r_m_valid && m_ready && r_m_last && (r_stat_mb != '1)) begin
        r_stat_mb <= r_stat_mb + 32'd1;
      end
      if (r_resync_err && (r_stat_resync != '1)) begin
        r_stat_resync <= r_stat_resync + 16'd1;
      end
    end
  end

  assign stat_mb_count     = r_stat_mb;
  assign stat_resync_count = r_stat_resync;
`endif

endmodule
